// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Two-requester arbiter in front of one single-port, write-first synchronous
// memory with a 1-cycle read latency. It accepts at most one access per cycle,
// drives the memory port, and returns the registered read data to the winning
// port one cycle later.
//
// Build option: MEM_ARB_FIXED_PRIO_EN
//   - When defined, port 0 always wins ties. last_grant is still tracked but
//     not used, so port 1 can starve.
//   - When undefined (default), ties alternate round-robin on last_grant.
module mem_port_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req_valid_0,
    output logic                     req_ready_0,
    input  logic                     req_we_0,
    input  logic [ADDRESS_WIDTH-1:0] req_addr_0,
    input  logic [DATA_WIDTH-1:0]    req_wdata_0,

    input  logic                     req_valid_1,
    output logic                     req_ready_1,
    input  logic                     req_we_1,
    input  logic [ADDRESS_WIDTH-1:0] req_addr_1,
    input  logic [DATA_WIDTH-1:0]    req_wdata_1,

    output logic                     rsp_valid_0,
    output logic [DATA_WIDTH-1:0]    rsp_rdata_0,
    output logic                     rsp_valid_1,
    output logic [DATA_WIDTH-1:0]    rsp_rdata_1,

    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_din,
    input  logic [DATA_WIDTH-1:0]    mem_dout
);

    // Port that won the most recent transfer; the other port wins the next tie.
    logic last_grant;
    // A response is due this cycle, and which port it belongs to.
    logic rsp_pend;
    logic rsp_owner;

    logic grant_0;
    logic grant_1;
    logic xfer;

    // Grant decision: a lone requester wins, and a tie goes by the priority
    // rule. No grant is given while reset is held.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (rst_n) begin
            if (req_valid_0 && req_valid_1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                grant_0 = 1'b1;
`else
                grant_0 = last_grant;
                grant_1 = ~last_grant;
`endif
            end else begin
                grant_0 = req_valid_0;
                grant_1 = req_valid_1;
            end
        end
    end

    assign req_ready_0 = grant_0;
    assign req_ready_1 = grant_1;
    assign xfer        = grant_0 | grant_1;

    // Memory port mux: it carries the granted port's fields. When there is no
    // grant it carries the port-0 fields, and the write enable is forced low.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = req_addr_0;
        mem_din  = req_wdata_0;
        if (grant_1) begin
            mem_we   = req_we_1;
            mem_addr = req_addr_1;
            mem_din  = req_wdata_1;
        end else if (grant_0) begin
            mem_we   = req_we_0;
        end
    end

    // Priority pointer and response tracking. Reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            rsp_pend   <= 1'b0;
            rsp_owner  <= 1'b0;
        end else begin
            rsp_pend <= xfer;
            if (xfer) begin
                last_grant <= grant_1;
                rsp_owner  <= grant_1;
            end else begin
                rsp_owner  <= 1'b0;
            end
        end
    end

    // Route the memory's registered output to the port that owns the response.
    always_comb begin
        rsp_valid_0 = rsp_pend & ~rsp_owner;
        rsp_valid_1 = rsp_pend &  rsp_owner;
        rsp_rdata_0 = rsp_valid_0 ? mem_dout : '0;
        rsp_rdata_1 = rsp_valid_1 ? mem_dout : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It includes a write-first single-port memory
// model and a scoreboard. Expected responses are queued when a transfer is
// granted and compared on the following cycle.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid_0 = 0, req_valid_1 = 0;
    logic          req_ready_0, req_ready_1;
    logic          req_we_0 = 0, req_we_1 = 0;
    logic [AW-1:0] req_addr_0 = '0, req_addr_1 = '0;
    logic [DW-1:0] req_wdata_0 = '0, req_wdata_1 = '0;
    logic          rsp_valid_0, rsp_valid_1;
    logic [DW-1:0] rsp_rdata_0, rsp_rdata_1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
        .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
        .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
        .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
        .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Write-first synchronous memory behind the arbiter.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_din;
            mem_dout      <= mem_din;
        end else begin
            mem_dout <= mem[mem_addr];
        end
    end

    // Scoreboard state: a shadow copy of memory and the expected priority pointer.
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    bit            m_last = 1'b1;

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
    } exp_t;
    exp_t q[$];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = (i * 32'h01010101) ^ 32'hA5A50000;
            shadow[i] = (i * 32'h01010101) ^ 32'hA5A50000;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // When reset is asserted, any queued response is discarded and the pointer returns to 1.
    always @(negedge rst_n) begin
        q.delete();
        m_last = 1'b1;
    end

    exp_t          e;
    bit            e_v;
    bit            g0, g1;
    logic [DW-1:0] d;

    // Compare the response owed from the previous cycle, then predict this cycle's grant.
    always @(negedge clk) begin
        e_v = 1'b0;
        e   = '{port: 1'b0, data: '0};
        if (q.size() > 0) begin
            e   = q.pop_front();
            e_v = 1'b1;
        end
        check_val("rsp_valid_0", rsp_valid_0, e_v && !e.port);
        check_val("rsp_valid_1", rsp_valid_1, e_v &&  e.port);
        check_val("rsp_rdata_0", rsp_rdata_0, (e_v && !e.port) ? e.data : '0);
        check_val("rsp_rdata_1", rsp_rdata_1, (e_v &&  e.port) ? e.data : '0);

        g0 = 1'b0;
        g1 = 1'b0;
        if (rst_n) begin
            if (req_valid_0 && req_valid_1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                g0 = 1'b1;
`else
                g0 = m_last;
                g1 = !m_last;
`endif
            end else begin
                g0 = req_valid_0;
                g1 = req_valid_1;
            end
        end
        check_val("req_ready_0", req_ready_0, g0);
        check_val("req_ready_1", req_ready_1, g1);
        check_val("mem_we", mem_we, g0 ? req_we_0 : (g1 ? req_we_1 : 1'b0));
        if (g0 || g1) begin
            check_val("mem_addr", mem_addr, g1 ? req_addr_1 : req_addr_0);
            check_val("mem_din", mem_din, g1 ? req_wdata_1 : req_wdata_0);
            if (g1) begin
                d = req_we_1 ? req_wdata_1 : shadow[req_addr_1];
                if (req_we_1) shadow[req_addr_1] = req_wdata_1;
            end else begin
                d = req_we_0 ? req_wdata_0 : shadow[req_addr_0];
                if (req_we_0) shadow[req_addr_0] = req_wdata_0;
            end
            m_last = g1;
            q.push_back('{port: g1, data: d});
        end
    end

    task automatic drive(input bit v0, input bit we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input bit we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req_valid_0 = v0; req_we_0 = we0; req_addr_0 = a0; req_wdata_0 = d0;
        req_valid_1 = v1; req_we_1 = we1; req_addr_1 = a1; req_wdata_1 = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        // Reset held while both ports request.
        req_valid_0 = 1; req_addr_0 = 10'h010;
        req_valid_1 = 1; req_addr_1 = 10'h020;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Contention: both ports read continuously.
        repeat (6) drive(1, 0, 10'h010, '0, 1, 0, 10'h020, '0);
        idle();

        // Port 1 alone: write, then read back the same address.
        drive(0, 0, '0, '0, 1, 1, 10'h005, 32'hDEADBEEF);
        drive(0, 0, '0, '0, 1, 0, 10'h005, '0);
        idle();

        // Read-after-write across ports at the top address.
        drive(1, 1, 10'h3FF, 32'h00000042, 0, 0, '0, '0);
        drive(0, 0, '0, '0, 1, 0, 10'h3FF, '0);
        idle();

        // Sustained tie for four cycles.
        repeat (4) drive(1, 0, 10'h3FF, '0, 1, 0, 10'h005, '0);
        idle();

        // Reset pulse while a read response is pending.
        drive(1, 0, 10'h005, '0, 0, 0, '0, '0);
        req_valid_0 = 0;
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 0, 10'h010, '0, 1, 0, 10'h020, '0);
        idle();

        // Random traffic over a small address window.
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom);
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
